// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the pipeline-stage record type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int          DATA_W   = 64;
  localparam logic [4:0]  ZERO_REG = 5'd31;

  // One destination-register result travelling down the pipeline.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/operand_bypass.sv
// Forward mux for one source operand: zero reg, MEM result, WB data, else RF.
// Latency: purely combinational.
// Backpressure: none; a MEM-stage load never forwards here, the top raises a stall.
module operand_bypass #(
  parameter int         DATA_W   = cpu_pkg::DATA_W,
  parameter logic [4:0] ZERO_REG = cpu_pkg::ZERO_REG
) (
  input  logic [4:0]        rs,
  input  logic [DATA_W-1:0] rf_rd,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] op
);

  // Priority select: newest producer wins; load results in MEM are not ready yet.
  always_comb begin
    op = rf_rd;
    if (rs == ZERO_REG) begin
      op = '0;
    end else if (mem_valid && mem_reg_write && !mem_mem_read && (mem_rd == rs)) begin
      op = mem_data;
    end else if (wb_valid && wb_reg_write && (wb_rd == rs)) begin
      op = wb_data;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// EX/MEM and MEM/WB result registers, RF write port, operand forwarding, load-use detect.
// Latency: EX in cycle N writes the RF in cycle N+2; operands/stall are combinational.
// Backpressure: never stalls itself; load_use_stall tells decode to hold and issue bubbles.
module regfile_writeback #(
  parameter int         DATA_W   = cpu_pkg::DATA_W,
  parameter logic [4:0] ZERO_REG = cpu_pkg::ZERO_REG
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic              flush,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              load_use_stall,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [4:0]        rf_write_reg,
  output logic              rf_reg_write
);

  cpu_pkg::stage_t   ex_mem_d, ex_mem_q;
  logic              wb_valid_d, wb_valid_q;
  logic              wb_reg_write_d, wb_reg_write_q;
  logic [4:0]        wb_rd_d, wb_rd_q;
  logic [DATA_W-1:0] wb_data_d, wb_data_q;

  // Next-state for both stages; flush only squashes the instruction entering MEM.
  always_comb begin
    ex_mem_d           = '0;
    ex_mem_d.valid     = ex_valid & ~flush;
    ex_mem_d.reg_write = ex_reg_write;
    ex_mem_d.mem_read  = ex_mem_read;
    ex_mem_d.rd        = ex_rd;
    ex_mem_d.data      = ex_result;

    wb_valid_d     = ex_mem_q.valid;
    wb_reg_write_d = ex_mem_q.reg_write;
    wb_rd_d        = ex_mem_q.rd;
    wb_data_d      = ex_mem_q.mem_read ? mem_load_data : ex_mem_q.data;
  end

  // Pipeline registers; reset drops every in-flight write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_mem_q       <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
    end else begin
      ex_mem_q       <= ex_mem_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
    end
  end

  // Register file write port straight from MEM/WB; the zero register is never written.
  assign rf_write_data = wb_data_q;
  assign rf_write_reg  = wb_rd_q;
  assign rf_reg_write  = wb_valid_q & wb_reg_write_q & (wb_rd_q != ZERO_REG);

  // A load in MEM has no data yet; any decode read of its destination must wait a cycle.
  assign load_use_stall = ex_mem_q.valid & ex_mem_q.mem_read & ex_mem_q.reg_write &
                          (ex_mem_q.rd != ZERO_REG) &
                          ((ex_mem_q.rd == id_rs1) | (ex_mem_q.rd == id_rs2));

  operand_bypass #(.DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_bypass_a (
    .rs            (id_rs1),
    .rf_rd         (rf_rd1),
    .mem_valid     (ex_mem_q.valid),
    .mem_reg_write (ex_mem_q.reg_write),
    .mem_mem_read  (ex_mem_q.mem_read),
    .mem_rd        (ex_mem_q.rd),
    .mem_data      (ex_mem_q.data),
    .wb_valid      (wb_valid_q),
    .wb_reg_write  (wb_reg_write_q),
    .wb_rd         (wb_rd_q),
    .wb_data       (wb_data_q),
    .op            (op_a)
  );

  operand_bypass #(.DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_bypass_b (
    .rs            (id_rs2),
    .rf_rd         (rf_rd2),
    .mem_valid     (ex_mem_q.valid),
    .mem_reg_write (ex_mem_q.reg_write),
    .mem_mem_read  (ex_mem_q.mem_read),
    .mem_rd        (ex_mem_q.rd),
    .mem_data      (ex_mem_q.data),
    .wb_valid      (wb_valid_q),
    .wb_reg_write  (wb_reg_write_q),
    .wb_rd         (wb_rd_q),
    .wb_data       (wb_data_q),
    .op            (op_b)
  );

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back and operand-bypass block for the 64-bit pipelined CPU. Holds the EX/MEM and MEM/WB pipeline registers for destination-register results. Drives the register file write port (data, register index, write enable). Returns forwarded read operands to the decode/execute boundary, so instructions issued back-to-back see the newest value of each register. Also flags load-use hazards to the hazard/stall logic.

## Interface
Parameters:
- DATA_W, 64, datapath width
- ZERO_REG, 31, hard-wired zero register index (never written, never forwarded)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a real instruction this cycle
- ex_reg_write  in  1  instruction writes a destination register
- ex_mem_read  in  1  instruction is a load (value not available until MEM)
- ex_rd  in  5  destination register index
- ex_result  in  DATA_W  ALU result / address-independent result
- mem_load_data  in  DATA_W  load data returned during the MEM cycle
- flush  in  1  squash instruction entering EX/MEM this edge
- id_rs1, id_rs2  in  5 each  source indices being read in decode
- rf_rd1, rf_rd2  in  DATA_W each  raw register file read data
- op_a, op_b  out  DATA_W each  forwarded operands
- load_use_stall  out  1  decode must hold; load result not yet available
- rf_write_data  out  DATA_W  register file write data
- rf_write_reg  out  5  register file write index
- rf_reg_write  out  1  register file write enable

## Operation
- EX/MEM register captures: valid = ex_valid & ~flush, plus reg_write, mem_read, rd, result.
- MEM/WB register captures the MEM stage: valid, reg_write, rd, and data = mem_read ? mem_load_data : result.
- Write port is driven directly from MEM/WB:
  - rf_write_data = wb.data
  - rf_write_reg = wb.rd
  - rf_reg_write = wb.valid & wb.reg_write & (wb.rd != ZERO_REG)
- Forwarding for each source rsX, first match wins:
  1. rsX == ZERO_REG -> 0.
  2. MEM stage valid & reg_write & ~mem_read & rd == rsX -> mem.result.
  3. WB stage valid & reg_write & rd == rsX -> wb.data.
  4. Otherwise -> rf_rdX.
- A MEM-stage load matching rsX does not forward. It asserts load_use_stall instead, and rsX resolves via rules 3–4 that cycle.
- load_use_stall = MEM valid & mem_read & reg_write & rd != ZERO_REG & (rd == id_rs1 | rd == id_rs2).
- The block does not stall itself. Upstream drives ex_valid=0 (a bubble) while a stall is held.
- flush affects only the EX/MEM capture. An instruction already in MEM/WB always completes.

## Timing
- Reset (async assert, sync release): both stage valids = 0; all data/rd fields = 0.
  - Outputs under reset: rf_reg_write=0, rf_write_reg=0, rf_write_data=0, load_use_stall=0.
  - op_a/op_b = rf_rd1/rf_rd2 (0 for ZERO_REG).
- Latency: an instruction in EX during cycle N drives the write port during cycle N+2. The register file updates at the end of cycle N+2.
- A same-cycle read of the register being written (cycle N+2) must return the new value, via rule 3.
- op_a, op_b and load_use_stall are combinational from state and id_rs*; no added latency.
- Load in EX at cycle N: load_use_stall is high in cycle N+1 if a dependent reads. In N+2 the value forwards from WB and the stall drops.
- Reset mid-operation discards all in-flight writes; no partial write.

## Structure
- Shared package (cpu_pkg): DATA_W and ZERO_REG constants, plus a stage_t struct {valid, reg_write, mem_read, rd, data}.
- One natural sub-module, operand_bypass: the combinational forward mux. Instantiate it twice, once per source.
- Pipeline registers live in the top module.

## Test plan
- Reset: hold reset_n=0 mid-stream → rf_reg_write=0 and load_use_stall=0 immediately. After release, the first write appears 2 cycles after the first valid EX.
- Back-to-back ALU: X1←5 at cycle 0, then read X1 at cycle 1 → op_a=5 via MEM forward. Read at cycle 2 → op_a=5 via WB forward while rf_rd1 is still stale.
- Priority: X2←7, then X2←9, then read X2 → op_b=9 (MEM wins over WB).
- Load-use: load X3 with mem_load_data=0xDEAD and the next instruction reads X3 → load_use_stall=1 for one cycle. With a bubble inserted, the following cycle gives op_a=0xDEAD and stall=0.
- Zero register: write X31←0x55 → rf_reg_write=0. A read of X31 in any cycle → 0, with no stall even if a load targets X31.
- Flush: ex_valid=1, rd=4, flush=1 → no write to X4 ever, and no forward of its result.
